// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers of the execute stage.
// Results are computed at accept time and committed after a fixed busy latency.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clock,
    input  logic        reset,
    // "use" is a reserved word in SystemVerilog, so the MDU-use command is named mdu_use
    input  logic        mdu_use,
    input  logic        start,
    input  logic [2:0]  operation,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] dataRead,
    output logic        busy
);

    localparam logic [2:0] OP_READ_HI  = 3'd0;
    localparam logic [2:0] OP_READ_LO  = 3'd1;
    localparam logic [2:0] OP_WRITE_HI = 3'd2;
    localparam logic [2:0] OP_WRITE_LO = 3'd3;
    localparam logic [2:0] OP_MULT     = 3'd4;
    localparam logic [2:0] OP_MULTU    = 3'd5;
    localparam logic [2:0] OP_DIV      = 3'd6;
    localparam logic [2:0] OP_DIVU     = 3'd7;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, COMPUTING} state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        pending_hi;
    logic [31:0]        pending_lo;
    logic               pending_commit;

    logic [63:0]        product_signed;
    logic [63:0]        product_unsigned;
    logic               divisor_zero;
    logic [31:0]        safe_divisor;
    logic [31:0]        quotient_unsigned;
    logic [31:0]        remainder_unsigned;
    logic [31:0]        dividend_mag;
    logic [31:0]        divisor_mag;
    logic [31:0]        quotient_mag;
    logic [31:0]        remainder_mag;
    logic [31:0]        quotient_signed;
    logic [31:0]        remainder_signed;

    logic [31:0]        result_hi;
    logic [31:0]        result_lo;
    logic               result_commit;
    logic [CNT_W-1:0]   result_cycles;
    logic               accept;

    // Low 64 bits of the product of sign-extended operands equal the signed product
    assign product_signed   = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    assign product_unsigned = {32'b0, operand1} * {32'b0, operand2};

    // A zero divisor never commits, so it is replaced by 1 to keep the divider well defined
    assign divisor_zero       = (operand2 == 32'd0);
    assign safe_divisor       = divisor_zero ? 32'd1 : operand2;
    assign quotient_unsigned  = operand1 / safe_divisor;
    assign remainder_unsigned = operand1 % safe_divisor;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally
    assign dividend_mag     = operand1[31] ? -operand1 : operand1;
    assign divisor_mag      = safe_divisor[31] ? -safe_divisor : safe_divisor;
    assign quotient_mag     = dividend_mag / divisor_mag;
    assign remainder_mag    = dividend_mag % divisor_mag;
    assign quotient_signed  = (operand1[31] ^ safe_divisor[31]) ? -quotient_mag : quotient_mag;
    assign remainder_signed = operand1[31] ? -remainder_mag : remainder_mag;

    always_comb begin
        result_hi     = 32'd0;
        result_lo     = 32'd0;
        result_commit = 1'b1;
        result_cycles = CNT_W'(MUL_CYCLES);
        case (operation)
            OP_MULT: begin
                result_hi = product_signed[63:32];
                result_lo = product_signed[31:0];
            end
            OP_MULTU: begin
                result_hi = product_unsigned[63:32];
                result_lo = product_unsigned[31:0];
            end
            OP_DIV: begin
                result_hi     = remainder_signed;
                result_lo     = quotient_signed;
                result_commit = !divisor_zero;
                result_cycles = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                result_hi     = remainder_unsigned;
                result_lo     = quotient_unsigned;
                result_commit = !divisor_zero;
                result_cycles = CNT_W'(DIV_CYCLES);
            end
            default: begin
                result_commit = 1'b0;
            end
        endcase
    end

    assign accept = mdu_use && start && operation[2] && (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            hi             <= 32'd0;
            lo             <= 32'd0;
            pending_hi     <= 32'd0;
            pending_lo     <= 32'd0;
            pending_commit <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pending_hi     <= result_hi;
                        pending_lo     <= result_lo;
                        pending_commit <= result_commit;
                        counter        <= result_cycles;
                        state          <= COMPUTING;
                        busy           <= 1'b1;
                    end else if (mdu_use && !start) begin
                        if (operation == OP_WRITE_HI) hi <= operand1;
                        if (operation == OP_WRITE_LO) lo <= operand1;
                    end
                end
                COMPUTING: begin
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
                        if (pending_commit) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        pending_commit <= 1'b0;
                        state          <= IDLE;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dataRead = 32'd0;
        if (mdu_use && operation == OP_READ_HI) dataRead = hi;
        else if (mdu_use && operation == OP_READ_LO) dataRead = lo;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: expected values are queued, then
// popped and checked against HI/LO reads, busy, and busy-cycle counts.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mdu_use;
    logic        start;
    logic [2:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] dataRead;
    logic        busy;

    int assertions = 0;
    int failures   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .mdu_use  (mdu_use),
        .start    (start),
        .operation(operation),
        .operand1 (operand1),
        .operand2 (operand2),
        .dataRead (dataRead),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic expectValue(input string tag, input logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        assertions++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty: observed %h expected <none>", observed);
        end else begin
            tag      = tag_q.pop_front();
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                failures++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // One command consumed by exactly one rising edge, then the bus returns to idle
    task automatic applyStimulus(input logic u, input logic s, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        mdu_use   = u;
        start     = s;
        operation = op;
        operand1  = a;
        operand2  = b;
        @(posedge clock);
        #1;
        mdu_use   = 1'b0;
        start     = 1'b0;
        operation = 3'd0;
    endtask

    task automatic readCheck(input string tag, input logic [2:0] op, input logic [31:0] value);
        mdu_use   = 1'b1;
        start     = 1'b0;
        operation = op;
        #1;
        expectValue(tag, value);
        checkOutput(dataRead);
        mdu_use   = 1'b0;
    endtask

    task automatic busyCheck(input string tag, input logic value);
        expectValue(tag, {31'b0, value});
        checkOutput({31'b0, busy});
    endtask

    // Counts busy cycles still remaining, bounded so a stuck busy cannot hang the run
    task automatic waitIdle(input int already, output int n);
        n = already;
        while (busy && n < 200) begin
            n++;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int          n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rand_hi;
        logic [31:0] rand_lo;
        longint      prod;

        reset = 1'b1; mdu_use = 1'b0; start = 1'b0; operation = 3'd0;
        operand1 = 32'd0; operand2 = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        $display("[TB] reset state");
        busyCheck("reset_busy", 1'b0);
        readCheck("reset_hi", 3'd0, 32'd0);
        readCheck("reset_lo", 3'd1, 32'd0);

        $display("[TB] signed multiply -2 * 3");
        applyStimulus(1'b1, 1'b1, 3'd4, 32'hFFFFFFFE, 32'd3);
        busyCheck("mult_busy_start", 1'b1);
        readCheck("mult_read_old_lo", 3'd1, 32'd0);
        waitIdle(0, n);
        expectValue("mult_busy_cycles", 32'd5);
        checkOutput(32'(n));
        readCheck("mult_hi", 3'd0, 32'hFFFFFFFF);
        readCheck("mult_lo", 3'd1, 32'hFFFFFFFA);

        $display("[TB] unsigned multiply max * max");
        applyStimulus(1'b1, 1'b1, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitIdle(0, n);
        expectValue("multu_busy_cycles", 32'd5);
        checkOutput(32'(n));
        readCheck("multu_hi", 3'd0, 32'hFFFFFFFE);
        readCheck("multu_lo", 3'd1, 32'h00000001);

        $display("[TB] signed divide -7 / 2");
        applyStimulus(1'b1, 1'b1, 3'd6, 32'hFFFFFFF9, 32'd2);
        waitIdle(0, n);
        expectValue("div_busy_cycles", 32'd10);
        checkOutput(32'(n));
        readCheck("div_lo", 3'd1, 32'hFFFFFFFD);
        readCheck("div_hi", 3'd0, 32'hFFFFFFFF);

        $display("[TB] unsigned divide by zero, with write ignored while busy");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h12345678, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'h12345678, 32'd0);
        readCheck("mthi_hi", 3'd0, 32'h12345678);
        readCheck("mtlo_lo", 3'd1, 32'h12345678);
        applyStimulus(1'b1, 1'b1, 3'd7, 32'd7, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000AAAA, 32'd0);
        waitIdle(1, n);
        expectValue("divu0_busy_cycles", 32'd10);
        checkOutput(32'(n));
        readCheck("divu0_hi", 3'd0, 32'h12345678);
        readCheck("divu0_lo", 3'd1, 32'h12345678);

        $display("[TB] signed divide overflow case");
        applyStimulus(1'b1, 1'b1, 3'd6, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(0, n);
        readCheck("divovf_lo", 3'd1, 32'h80000000);
        readCheck("divovf_hi", 3'd0, 32'h00000000);

        $display("[TB] random signed multiply and unsigned divide");
        ra = $urandom;
        rb = $urandom;
        prod = longint'($signed(ra)) * longint'($signed(rb));
        applyStimulus(1'b1, 1'b1, 3'd4, ra, rb);
        waitIdle(0, n);
        readCheck("rand_mult_hi", 3'd0, prod[63:32]);
        readCheck("rand_mult_lo", 3'd1, prod[31:0]);
        ra = $urandom;
        rb = ($urandom & 32'h0000FFFF) | 32'd1;
        rand_lo = ra / rb;
        rand_hi = ra % rb;
        applyStimulus(1'b1, 1'b1, 3'd7, ra, rb);
        waitIdle(0, n);
        readCheck("rand_divu_lo", 3'd1, rand_lo);
        readCheck("rand_divu_hi", 3'd0, rand_hi);

        $display("[TB] ignored start combinations");
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h1, 32'h1);
        busyCheck("start_read_ignored", 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd5, 32'h3, 32'h3);
        busyCheck("start_no_use_ignored", 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd2, 32'hFFFF0000, 32'd0);
        readCheck("start_write_ignored", 3'd0, rand_hi);
        mdu_use = 1'b0; operation = 3'd0;
        #1;
        expectValue("read_no_use", 32'd0);
        checkOutput(dataRead);

        $display("[TB] reset abandons an operation in flight");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'hCAFEBABE, 32'd0);
        readCheck("mthi_cafe", 3'd0, 32'hCAFEBABE);
        applyStimulus(1'b1, 1'b1, 3'd4, 32'd3, 32'd4);
        applyStimulus(1'b1, 1'b1, 3'd4, 32'd5, 32'd6);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'h0000DEAD, 32'd0);
        busyCheck("busy_cycle3", 1'b1);
        readCheck("busy_mtlo_ignored", 3'd1, rand_lo);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        busyCheck("midop_reset_busy", 1'b0);
        readCheck("midop_reset_hi", 3'd0, 32'd0);
        readCheck("midop_reset_lo", 3'd1, 32'd0);
        repeat (12) @(posedge clock);
        #1;
        busyCheck("post_reset_busy", 1'b0);
        readCheck("post_reset_hi", 3'd0, 32'd0);
        readCheck("post_reset_lo", 3'd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO registers in the execute stage.
- Executes the MDU commands produced by instruction decode (mduUse, mduStart, mduOperation) on execute-stage operands.
- Raises busy so the hazard logic stalls any later MDU instruction at decode.
- Supplies HI/LO read data to the register write-back mux.

Parameters:
MUL_CYCLES, 5, busy cycles after a multiply is accepted (>=1)
DIV_CYCLES, 10, busy cycles after a divide is accepted (>=1)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
use  input  1  instruction in execute uses the MDU (mduUse)
start  input  1  command starts an arithmetic operation (mduStart)
operation  input  3  READ_HI=0, READ_LO=1, WRITE_HI=2, WRITE_LO=3, START_SIGNED_MUL=4, START_UNSIGNED_MUL=5, START_SIGNED_DIV=6, START_UNSIGNED_DIV=7
operand1  input  32  rs value after forwarding
operand2  input  32  rt value after forwarding
dataRead  output  32  HI or LO for MFHI/MFLO
busy  output  1  arithmetic operation in flight

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, state=IDLE, counter=0, pending results cleared, busy=0. Reset asserted mid-operation abandons the operation; HI/LO stay 0.
- States:
  - IDLE: busy=0.
  - COMPUTING: busy=1.
  - busy is registered, equal to (state==COMPUTING).
- Accept: use=1, start=1, operation in 4..7, state IDLE.
  - Compute the result combinationally from operand1/operand2.
  - Latch it into pendingHi/pendingLo.
  - Load counter with MUL_CYCLES (ops 4,5) or DIV_CYCLES (ops 6,7).
  - Go to COMPUTING.
- Any other start combination is ignored: use=0, or operation 0..3 with start=1.
- COMPUTING: counter decrements each cycle. On the edge where counter==1, HI<=pendingHi, LO<=pendingLo, state<=IDLE.
- busy is therefore high for exactly N cycles, starting the cycle after accept.
- New results are visible on dataRead the first cycle busy is low again.
- Multiply: {HI,LO} = 64-bit product. Signed for op 4 (sign-extend both operands to 64 bits), unsigned for op 5.
- Divide:
  - LO = quotient, HI = remainder.
  - Signed (op 6): truncate toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Unsigned: op 7.
  - Divisor 0: the operation is still accepted and still busy for DIV_CYCLES; HI/LO are left unchanged at commit.
- WRITE_HI/WRITE_LO (use=1, start=0, state IDLE): HI or LO <= operand1 on that edge. The other register is unchanged.
- Commands while busy:
  - Any use=1 command (start, write or read) is ignored; HI/LO are not modified.
  - Decode must stall such instructions; ignoring them is the defined fallback, not an error.
- Reads: dataRead is combinational.
  - = HI when use=1 and operation=READ_HI.
  - = LO when use=1 and operation=READ_LO.
  - = 0 otherwise.
  - While busy, reads return the committed (old) HI/LO, never pending values.
- Same-cycle write and read cannot occur: there is one command per cycle.
- A read in the cycle after a write sees the new value.

Test Plan:
- Reset, then use=1 op=READ_HI -> dataRead=0, busy=0. Same with op=READ_LO -> dataRead=0.
- MULT operand1=0xFFFFFFFE (-2), operand2=3:
  - busy=1 for exactly 5 cycles.
  - During busy, READ_LO returns the old value.
  - After busy falls, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU operand1=0xFFFFFFFF, operand2=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
- DIV operand1=-7, operand2=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU operand1=7, operand2=0 with HI=LO=0x12345678 beforehand:
  - busy for 10 cycles.
  - HI/LO remain 0x12345678.
- MTHI operand1=0xCAFEBABE, then issue MULT:
  - During busy, a second MULT and an MTLO are ignored.
  - At cycle 3 of busy, assert reset -> busy=0, HI=LO=0 next cycle, no later commit.
